// File: rtl/mem_access_unit.sv
// Strided load/store burst sequencer in front of the image data memory.
// Define MAU_BOUNDS_CHECK_EN to enable the MEM_DEPTH range check and the err flag.
module mem_access_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 49152,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [ADDR_W-1:0] req_stride,
    input  logic [CNT_W-1:0]  req_count,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_inputData,
    output logic              mem_writeEnable,
    input  logic [DATA_W-1:0] mem_out
);

    // Handshakes: a transfer happens on every rising clk edge where valid && ready.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  remaining;
    logic              rd_pending;
    logic              accept;
    logic              in_range;
    logic              issue_rd;
    logic              wr_hs;
    logic              last_word;

    assign accept    = (state == S_IDLE) && req_valid;
    assign issue_rd  = (state == S_READ) && in_range;
    assign wr_hs     = (state == S_WRITE) && in_range && wdata_valid;
    assign last_word = (remaining == CNT_W'(1));

`ifdef MAU_BOUNDS_CHECK_EN
    logic err_q;

    assign in_range = (32'(addr) < 32'(MEM_DEPTH));
    assign err      = err_q;

    // Sticky until the next command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == S_READ || state == S_WRITE) && !in_range) begin
            err_q <= 1'b1;
        end
    end
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_count == '0) begin
                        state_nxt = S_DONE;
                    end else if (req_write) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (!in_range) begin
                    state_nxt = rd_pending ? S_DRAIN : S_DONE;
                end else if (last_word) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: state_nxt = S_DONE;
            S_WRITE: begin
                if (!in_range) begin
                    state_nxt = S_DONE;
                end else if (wdata_valid && last_word) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; the write strobe is gated by rst so a reset cycle never writes.
    always_comb begin
        req_ready       = (state == S_IDLE);
        wdata_ready     = (state == S_WRITE) && in_range;
        done            = (state == S_DONE);
        mem_writeEnable = wr_hs && !rst;
        mem_inputData   = (state == S_WRITE) ? wdata : '0;
        rdata_valid     = rd_pending;
        rdata           = rd_pending ? mem_out : '0;
    end

    assign mem_address = addr;

    // Burst datapath: address walker, word counter and read-latency tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            stride     <= '0;
            remaining  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue_rd;
            if (accept) begin
                addr      <= req_base;
                stride    <= req_stride;
                remaining <= req_count;
            end else if (issue_rd || wr_hs) begin
                addr      <= addr + stride;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a memory model feeds the DUT while a
// scoreboard of expected reads/writes, computed from burst arithmetic, checks it.
module tb_mem_access_unit;

  localparam int DEPTH = 49152;
`ifdef MAU_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_base = '0;
  logic [15:0] req_stride = '0;
  logic [7:0]  req_count = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [63:0] wdata = '0;
  logic        rdata_valid;
  logic [63:0] rdata;
  logic        done;
  logic        err;
  logic [15:0] mem_address;
  logic [63:0] mem_inputData;
  logic        mem_writeEnable;
  logic [63:0] mem_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cnt = 0;

  logic [63:0] mem_array [0:65535];
  logic [63:0] ref_mem [0:65535];
  logic [63:0] exp_rd_q[$];
  logic [15:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];

  mem_access_unit #(
    .ADDR_W(16), .DATA_W(64), .MEM_DEPTH(DEPTH), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_base(req_base), .req_stride(req_stride), .req_count(req_count),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .mem_address(mem_address), .mem_inputData(mem_inputData),
    .mem_writeEnable(mem_writeEnable), .mem_out(mem_out)
  );

  // clock / memory block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_writeEnable) mem_array[mem_address] <= mem_inputData;
    mem_out <= mem_array[mem_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every write and every returned read is matched against the queues
  always @(negedge clk) begin
    logic [15:0] a;
    logic [63:0] d;
    if (mem_writeEnable) begin
      check("we_valid", {63'd0, wdata_valid}, 64'd1);
      check("we_rst", {63'd0, rst}, 64'd0);
      if (exp_wa_q.size() == 0) begin
        check("wr_extra", {63'd0, mem_writeEnable}, 64'd0);
      end else begin
        a = exp_wa_q.pop_front();
        d = exp_wd_q.pop_front();
        check("wr_addr", {48'd0, mem_address}, {48'd0, a});
        check("wr_data", mem_inputData, d);
        ref_mem[a] = d;
      end
    end
    if (rdata_valid) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_extra", {63'd0, rdata_valid}, 64'd0);
      end else begin
        d = exp_rd_q.pop_front();
        check("rd_data", rdata, d);
      end
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic send_cmd(input logic wr, input logic [15:0] base, input logic [15:0] stride,
                          input logic [7:0] count);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_base = base; req_stride = stride; req_count = count;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    accept_cyc = cyc;
  endtask

  task automatic finish_burst(input string tag, input logic exp_err);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
    check({tag, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
    check({tag, "_wr_left"}, 64'(exp_wa_q.size()), 64'd0);
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    @(negedge clk);
    check({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
  endtask

  task automatic run_load(input string tag, input logic [15:0] base, input logic [15:0] stride,
                          input logic [7:0] count);
    logic [15:0] a;
    logic exp_err = 1'b0;
    int n = 0;
    for (int i = 0; i < int'(count); i++) begin
      a = base + 16'(i) * stride;
      if (BOUNDS && int'(a) >= DEPTH) begin exp_err = 1'b1; break; end
      exp_rd_q.push_back(ref_mem[a]);
    end
    send_cmd(1'b0, base, stride, count);
    while (!done && n < 300) begin @(negedge clk); n++; end
    if (!exp_err) check({tag, "_lat"}, 64'(cyc - accept_cyc + 1), (count == 0) ? 64'd1 : 64'(count) + 64'd2);
    finish_burst(tag, exp_err);
  endtask

  // mode 0: valid every other cycle, 1: random, 2: always valid
  task automatic run_store(input string tag, input logic [15:0] base, input logic [15:0] stride,
                           input logic [7:0] count, input int mode);
    logic [63:0] data[$];
    logic [15:0] a;
    logic exp_err = 1'b0;
    int exp_n = 0;
    int idx = 0;
    int n = 0;
    int last_hs = 0;
    bit alt = 1'b0;
    for (int i = 0; i < int'(count); i++) data.push_back({$urandom, $urandom});
    for (int i = 0; i < int'(count); i++) begin
      a = base + 16'(i) * stride;
      if (BOUNDS && int'(a) >= DEPTH) begin exp_err = 1'b1; break; end
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(data[i]);
      exp_n++;
    end
    send_cmd(1'b1, base, stride, count);
    while (!done && n < 300) begin
      if (wdata_valid && wdata_ready) begin idx++; last_hs = cyc; end
      @(posedge clk); #1;
      alt = ~alt;
      wdata_valid = (idx < int'(count)) &&
                    ((mode == 0) ? alt : (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (idx < int'(count)) wdata = data[idx];
      @(negedge clk);
      n++;
    end
    wdata_valid = 1'b0;
    check({tag, "_hs"}, 64'(idx), 64'(exp_n));
    if (count == 0) check({tag, "_lat0"}, 64'(cyc - accept_cyc + 1), 64'd1);
    else if (!exp_err) check({tag, "_lat"}, 64'(cyc - last_hs), 64'd1);
    finish_burst(tag, exp_err);
  endtask

  task automatic reset_mid_store();
    logic [63:0] d0, d1;
    int snap;
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    exp_wa_q.push_back(16'h0200);
    exp_wd_q.push_back(d0);
    send_cmd(1'b1, 16'h0200, 16'h0001, 8'd8);
    @(posedge clk); #1;
    wdata_valid = 1'b1; wdata = d0;
    @(negedge clk);
    check("rst_ready0", {63'd0, wdata_ready}, 64'd1);
    @(posedge clk); #1;
    wdata = d1; rst = 1'b1;
    @(negedge clk);
    check("rst_we_gated", {63'd0, mem_writeEnable}, 64'd0);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    snap = done_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_no_we", {63'd0, mem_writeEnable}, 64'd0);
    end
    check("rst_no_done", 64'(done_cnt - snap), 64'd0);
    check("rst_wr_left", 64'(exp_wa_q.size()), 64'd0);
    exp_wa_q.delete(); exp_wd_q.delete();
  endtask

  initial begin
    logic [63:0] v;
    logic [15:0] base;
    for (int i = 0; i < 65536; i++) begin
      v = {$urandom, $urandom};
      mem_array[i] <= v;
      ref_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_wdata_ready", {63'd0, wdata_ready}, 64'd0);
    check("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_we", {63'd0, mem_writeEnable}, 64'd0);
    check("rst_addr", {48'd0, mem_address}, 64'd0);
    check("rst_wdata", mem_inputData, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      v = 64'hA0A0_0000_0000_0000 + 64'(i);
      mem_array[16 + i] <= v;
      ref_mem[16 + i] = v;
    end
    run_load("load_basic", 16'h0010, 16'h0001, 8'd4);
    run_store("store_stall", 16'h0100, 16'h0003, 8'd3, 0);
    run_load("load_back", 16'h0100, 16'h0003, 8'd3);
    run_load("load_cnt0", 16'h0020, 16'h0001, 8'd0);
    run_store("store_cnt0", 16'h0020, 16'h0001, 8'd0, 2);
    run_load("load_edge", 16'hBFFE, 16'h0001, 8'd4);
    run_store("store_wrap", 16'hFFFF, 16'h0002, 8'd2, 2);
    run_load("load_wrap", 16'hFFFF, 16'h0002, 8'd2);
    reset_mid_store();
    run_load("load_after_rst", 16'h0200, 16'h0001, 8'd4);

    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 2))
        0: base = 16'($urandom_range(0, 65535));
        1: base = 16'hBFF0 + 16'($urandom_range(0, 31));
        default: base = 16'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1)
        run_store("rnd_store", base, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 10)), 1);
      else
        run_load("rnd_load", base, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 10)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer directly upstream of the 64-bit image data memory (16-bit word address, 49152 words, registered read with 1-cycle latency, write on writeEnable).
- Takes a strided burst command (base, stride, count, load/store) from the processing pipeline and drives the memory address, data and write-enable ports word by word.
- Returns read words as a valid-qualified stream and accepts store words through a valid/ready stream.
- Signals completion and any out-of-range error.

Parameters:
ADDR_W, 16, word address width
DATA_W, 64, data word width
MEM_DEPTH, 49152, number of valid word addresses (0..MEM_DEPTH-1)
CNT_W, 8, burst count width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready
req_write  in  1  1 = store burst, 0 = load burst
req_base  in  ADDR_W  first word address
req_stride  in  ADDR_W  address increment per word, unsigned
req_count  in  CNT_W  words in burst; 0 = empty burst
wdata_valid  in  1  store word valid
wdata_ready  out  1  store word consumed when wdata_valid && wdata_ready
wdata  in  DATA_W  store word
rdata_valid  out  1  load word valid, 1-cycle pulse per word, no backpressure
rdata  out  DATA_W  load word
done  out  1  1-cycle pulse at burst end
err  out  1  sticky out-of-range flag, cleared on next command acceptance
mem_address  out  ADDR_W  to memory address
mem_inputData  out  DATA_W  to memory write data
mem_writeEnable  out  1  to memory write enable
mem_out  in  DATA_W  from memory read data (registered, valid 1 cycle after address)

Behaviour:
- Reset (rst sampled high at posedge): state IDLE.
  - req_ready=1 after reset; wdata_ready, rdata_valid, done, err, mem_writeEnable = 0.
  - mem_address = 0, mem_inputData = 0, rdata = 0, internal counters cleared.
  - rst is also gated into mem_writeEnable, so no write is issued in any cycle where rst=1.
  - Reset mid-burst abandons the burst with no done pulse. A read issued before reset never produces rdata_valid.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: req_ready=1. On acceptance:
  - Latch write, base, stride and count; set addr=base, remaining=count; clear err.
  - count==0 -> DONE; write=1 -> WRITE; else -> READ.
- READ:
  - Each cycle drive mem_address=addr with mem_writeEnable=0.
  - Then addr <= addr+stride (mod 2^ADDR_W wrap) and remaining <= remaining-1.
  - The cycle after each issue: rdata_valid=1, rdata=mem_out.
  - When remaining reaches 1 (last issue) -> DRAIN.
- DRAIN: one cycle carrying the final rdata_valid, then -> DONE.
- WRITE:
  - wdata_ready=1. mem_address=addr and mem_inputData=wdata (combinational).
  - mem_writeEnable = wdata_valid && !rst.
  - On each handshake, advance addr and remaining as in READ. On the last handshake -> DONE.
  - wdata_valid low: stall, no write.
- DONE: done=1 for one cycle, req_ready=0, then -> IDLE. A new command can be accepted in the following cycle.
- Bounds check:
  - Before each issue, test addr >= MEM_DEPTH.
  - If true: no memory access for that word, err<=1, jump to DONE. For loads, DRAIN is taken first if a read is outstanding.
  - Words already transferred stand.
- Address wrap: addr+stride beyond 2^ADDR_W-1 wraps modulo 2^ADDR_W, then the bounds check applies.
- Throughput: load = count+2 cycles from acceptance to done (1 word/cycle). Store = count handshakes + 1.

Optional Feature:
- Macro MAU_BOUNDS_CHECK_EN.
- Defined: bounds check as above; err functional.
- Undefined: no range test. Every address is issued raw after modulo-2^ADDR_W wrap. err is tied to 0 and a burst always runs to count words.

Test Plan:
- Load base=0x0010, stride=1, count=4, memory preloaded mem[0x10..0x13]=A,B,C,D -> mem_address 0x10..0x13 on consecutive cycles; rdata_valid 4 consecutive cycles with A,B,C,D; done at cycle 6 after acceptance; err=0.
- Store base=0x0100, stride=3, count=3, wdata_valid low every other cycle -> writes only on handshakes to 0x100, 0x103, 0x106; no mem_writeEnable while stalled; done after 3rd handshake.
- count=0 command -> no memory access; done the cycle after acceptance; req_ready back high next cycle.
- Load base=0xBFFE, stride=1, count=4 (MEM_DEPTH=49152) -> reads 0xBFFE, 0xBFFF only; 2 rdata_valid pulses; err=1; done pulses. With the macro undefined -> 4 reads to 0xBFFE..0xC001, err=0.
- Store base=0xFFFF, stride=2, count=2, macro undefined -> addresses 0xFFFF then 0x0001 (wrap).
- rst asserted during 2nd word of a count=8 store -> no further mem_writeEnable, no done; req_ready=1 after reset; next load executes normally.
